// File: rtl/bulls_cows_engine.sv
// ----------------------------------------------------------------------------
// bulls_cows_engine
//
// Bulls-and-Cows (xA yB) game core. The first legal number after a new game
// becomes the secret. Each later legal number is scored against it: bulls are
// right digit in the right place, cows are right digit in the wrong place.
// Every scored guess also goes into a small circular history that the text
// renderer reads combinationally.
//
// Optional feature macro: SECRET_REVEAL_EN
//   defined   : secret_out shows the latched secret while state == LOSE.
//   undefined : secret_out is tied to zero and no reveal logic exists.
//
// Parameters
//   DIGITS      digits per secret/guess (2..4)
//   MAX_TRIES   guesses allowed before LOSE (1..15)
//   HIST_DEPTH  history entries, power of two (2..16)
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   iNum           in   packed BCD digits, digit0 = iNum[3:0]
//   iNumRdy        in   1-cycle strobe, iNum valid
//   new_game       in   1-cycle strobe, back to IDLE and clear the game
//   state          out  00 IDLE, 01 PLAY, 10 WIN, 11 LOSE
//   score_vld      out  1-cycle pulse, score_a/score_b updated
//   score_a        out  bulls of the last scored guess
//   score_b        out  cows of the last scored guess
//   err            out  1-cycle pulse, input rejected
//   tries          out  accepted guesses this game
//   hist_cnt       out  valid history entries, saturates at HIST_DEPTH
//   hist_rd_idx    in   history read index, 0 = newest
//   hist_rd_guess  out  guess at hist_rd_idx (zero if not valid)
//   hist_rd_a      out  bulls of that entry
//   hist_rd_b      out  cows of that entry
//   secret_out     out  revealed secret (see macro above)
// ----------------------------------------------------------------------------
module bulls_cows_engine #(
    parameter int unsigned DIGITS     = 3,
    parameter int unsigned MAX_TRIES  = 10,
    parameter int unsigned HIST_DEPTH = 8,
    localparam int unsigned NW = 4 * DIGITS,
    localparam int unsigned SW = $clog2(DIGITS + 1),
    localparam int unsigned PW = $clog2(HIST_DEPTH),
    localparam int unsigned CW = $clog2(HIST_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [NW-1:0] iNum,
    input  logic          iNumRdy,
    input  logic          new_game,
    output logic [1:0]    state,
    output logic          score_vld,
    output logic [SW-1:0] score_a,
    output logic [SW-1:0] score_b,
    output logic          err,
    output logic [3:0]    tries,
    output logic [CW-1:0] hist_cnt,
    input  logic [PW-1:0] hist_rd_idx,
    output logic [NW-1:0] hist_rd_guess,
    output logic [SW-1:0] hist_rd_a,
    output logic [SW-1:0] hist_rd_b,
    output logic [NW-1:0] secret_out
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StPlay = 2'b01,
        StWin  = 2'b10,
        StLose = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic [NW-1:0] secret_q, secret_d;
    logic [3:0]    tries_q, tries_d;
    logic [SW-1:0] a_q, a_d;
    logic [SW-1:0] b_q, b_d;
    logic          vld_q, vld_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          wr_en;

    logic          legal;
    logic [SW-1:0] bulls;
    logic [SW-1:0] cows;

    logic [NW-1:0] hist_guess [HIST_DEPTH];
    logic [SW-1:0] hist_a     [HIST_DEPTH];
    logic [SW-1:0] hist_b     [HIST_DEPTH];

    logic [PW-1:0] rd_addr;
    logic          rd_hit;

    // Legal input: every digit is BCD and no digit repeats.
    always_comb begin
        legal = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (iNum[4*i +: 4] > 4'd9) begin
                legal = 1'b0;
            end
            for (int j = i + 1; j < DIGITS; j++) begin
                if (iNum[4*i +: 4] == iNum[4*j +: 4]) begin
                    legal = 1'b0;
                end
            end
        end
    end

    // Pairwise digit compare against the secret. Only used for legal guesses,
    // so distinct digits keep both counts within DIGITS.
    always_comb begin
        bulls = '0;
        cows  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            for (int j = 0; j < DIGITS; j++) begin
                if (iNum[4*i +: 4] == secret_q[4*j +: 4]) begin
                    if (i == j) begin
                        bulls = bulls + SW'(1);
                    end else begin
                        cows = cows + SW'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        secret_d = secret_q;
        tries_d  = tries_q;
        a_d      = a_q;
        b_d      = b_q;
        vld_d    = 1'b0;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        wr_en    = 1'b0;

        if (new_game) begin
            // new_game has priority; a coincident strobe is dropped.
            state_d  = StIdle;
            secret_d = '0;
            tries_d  = '0;
            a_d      = '0;
            b_d      = '0;
            cnt_d    = '0;
            ptr_d    = '0;
        end else if (iNumRdy && (state_q == StIdle || state_q == StPlay)) begin
            if (!legal) begin
                err_d = 1'b1;
            end else if (state_q == StIdle) begin
                secret_d = iNum;
                state_d  = StPlay;
            end else begin
                vld_d   = 1'b1;
                a_d     = bulls;
                b_d     = cows;
                tries_d = tries_q + 4'd1;
                wr_en   = 1'b1;
                ptr_d   = ptr_q + PW'(1);
                if (cnt_q != CW'(HIST_DEPTH)) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (bulls == SW'(DIGITS)) begin
                    state_d = StWin;
                end else if (tries_d == 4'(MAX_TRIES)) begin
                    state_d = StLose;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            secret_q <= '0;
            tries_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            secret_q <= secret_d;
            tries_q  <= tries_d;
            a_q      <= a_d;
            b_q      <= b_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
        end
    end

    // Entries beyond hist_cnt are masked on read, so storage needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            hist_guess[ptr_q] <= iNum;
            hist_a[ptr_q]     <= bulls;
            hist_b[ptr_q]     <= cows;
        end
    end

    // Power-of-two depth: pointer arithmetic wraps naturally.
    assign rd_addr = ptr_q - PW'(1) - hist_rd_idx;
    assign rd_hit  = (CW'(hist_rd_idx) < cnt_q);

    assign hist_rd_guess = rd_hit ? hist_guess[rd_addr] : '0;
    assign hist_rd_a     = rd_hit ? hist_a[rd_addr]     : '0;
    assign hist_rd_b     = rd_hit ? hist_b[rd_addr]     : '0;

    assign state     = state_q;
    assign score_vld = vld_q;
    assign score_a   = a_q;
    assign score_b   = b_q;
    assign err       = err_q;
    assign tries     = tries_q;
    assign hist_cnt  = cnt_q;

`ifdef SECRET_REVEAL_EN
    assign secret_out = (state_q == StLose) ? secret_q : '0;
`else
    assign secret_out = '0;
`endif

endmodule

// File: tb/tb_bulls_cows_engine.sv
// Testbench for bulls_cows_engine (default parameters). A behavioural game
// model is advanced on every clock edge and compared against the DUT on
// every falling edge; directed sequences add literal expectations.
module tb_bulls_cows_engine;

    localparam int DIGITS     = 3;
    localparam int MAX_TRIES  = 10;
    localparam int HIST_DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] iNum = '0;
    logic        iNumRdy = 1'b0;
    logic        new_game = 1'b0;
    logic [2:0]  hist_rd_idx = '0;

    logic [1:0]  state;
    logic        score_vld;
    logic [1:0]  score_a;
    logic [1:0]  score_b;
    logic        err;
    logic [3:0]  tries;
    logic [3:0]  hist_cnt;
    logic [11:0] hist_rd_guess;
    logic [1:0]  hist_rd_a;
    logic [1:0]  hist_rd_b;
    logic [11:0] secret_out;

    bulls_cows_engine #(
        .DIGITS    (DIGITS),
        .MAX_TRIES (MAX_TRIES),
        .HIST_DEPTH(HIST_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .iNum         (iNum),
        .iNumRdy      (iNumRdy),
        .new_game     (new_game),
        .state        (state),
        .score_vld    (score_vld),
        .score_a      (score_a),
        .score_b      (score_b),
        .err          (err),
        .tries        (tries),
        .hist_cnt     (hist_cnt),
        .hist_rd_idx  (hist_rd_idx),
        .hist_rd_guess(hist_rd_guess),
        .hist_rd_a    (hist_rd_a),
        .hist_rd_b    (hist_rd_b),
        .secret_out   (secret_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_state = 0;   // 0 idle, 1 play, 2 win, 3 lose
    int          m_tries = 0;
    int          m_a = 0;
    int          m_b = 0;
    bit          m_vld = 0;
    bit          m_err = 0;
    logic [11:0] m_secret = '0;
    logic [11:0] mh_g [HIST_DEPTH];  // newest first
    int          mh_a [HIST_DEPTH];
    int          mh_b [HIST_DEPTH];
    int          m_hcnt = 0;

    function automatic bit is_legal(input logic [11:0] v);
        int d [DIGITS];
        for (int k = 0; k < DIGITS; k++) begin
            d[k] = int'((v >> (4 * k)) & 12'hF);
            if (d[k] > 9) return 0;
        end
        for (int k = 0; k < DIGITS; k++)
            for (int m = 0; m < k; m++)
                if (d[k] == d[m]) return 0;
        return 1;
    endfunction

    // Bulls = positional matches; cows = digits common to both minus bulls.
    task automatic score_of(input logic [11:0] g, input logic [11:0] s,
                            output int a, output int b);
        int common;
        a = 0;
        common = 0;
        for (int k = 0; k < DIGITS; k++) begin
            if (((g >> (4 * k)) & 12'hF) == ((s >> (4 * k)) & 12'hF)) a++;
            for (int m = 0; m < DIGITS; m++)
                if (((g >> (4 * k)) & 12'hF) == ((s >> (4 * m)) & 12'hF)) begin
                    common++;
                    break;
                end
        end
        b = common - a;
    endtask

    always @(posedge clk or negedge reset) begin
        int a, b;
        if (!reset) begin
            m_state = 0; m_tries = 0; m_a = 0; m_b = 0;
            m_vld = 0; m_err = 0; m_secret = '0; m_hcnt = 0;
        end else begin
            m_vld = 0;
            m_err = 0;
            if (new_game) begin
                m_state = 0; m_tries = 0; m_a = 0; m_b = 0;
                m_secret = '0; m_hcnt = 0;
            end else if (iNumRdy && (m_state == 0 || m_state == 1)) begin
                if (!is_legal(iNum)) begin
                    m_err = 1;
                end else if (m_state == 0) begin
                    m_secret = iNum;
                    m_state = 1;
                end else begin
                    score_of(iNum, m_secret, a, b);
                    m_a = a; m_b = b; m_vld = 1;
                    m_tries++;
                    for (int k = HIST_DEPTH - 1; k > 0; k--) begin
                        mh_g[k] = mh_g[k-1]; mh_a[k] = mh_a[k-1]; mh_b[k] = mh_b[k-1];
                    end
                    mh_g[0] = iNum; mh_a[0] = a; mh_b[0] = b;
                    if (m_hcnt < HIST_DEPTH) m_hcnt++;
                    if (a == DIGITS) m_state = 2;
                    else if (m_tries == MAX_TRIES) m_state = 3;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int idx;
        logic [11:0] exp_sec;
        idx = int'(hist_rd_idx);
        check("state", state, m_state);
        check("score_vld", score_vld, m_vld);
        check("score_a", score_a, m_a);
        check("score_b", score_b, m_b);
        check("err", err, m_err);
        check("tries", tries, m_tries);
        check("hist_cnt", hist_cnt, m_hcnt);
        check("hist_rd_guess", hist_rd_guess, (idx < m_hcnt) ? mh_g[idx] : 12'h0);
        check("hist_rd_a", hist_rd_a, (idx < m_hcnt) ? mh_a[idx] : 0);
        check("hist_rd_b", hist_rd_b, (idx < m_hcnt) ? mh_b[idx] : 0);
`ifdef SECRET_REVEAL_EN
        exp_sec = (m_state == 3) ? m_secret : 12'h0;
`else
        exp_sec = 12'h0;
`endif
        check("secret_out", secret_out, exp_sec);
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [11:0] v);
        iNum = v;
        iNumRdy = 1'b1;
        hist_rd_idx = 3'($urandom_range(0, 7));
        cyc();
        iNumRdy = 1'b0;
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        cyc();
        new_game = 1'b0;
    endtask

    function automatic logic [11:0] rand_legal();
        int d0, d1, d2;
        d0 = $urandom_range(0, 9);
        do d1 = $urandom_range(0, 9); while (d1 == d0);
        do d2 = $urandom_range(0, 9); while (d2 == d0 || d2 == d1);
        return 12'((d2 << 8) | (d1 << 4) | d0);
    endfunction

    logic [11:0] g_list [10] = '{12'h045, 12'h056, 12'h067, 12'h078, 12'h089,
                                 12'h091, 12'h012, 12'h024, 12'h036, 12'h987};

    initial begin
        repeat (3) cyc();
        check("rst_state", state, 0);
        check("rst_tries", tries, 0);
        check("rst_hist_cnt", hist_cnt, 0);
        reset = 1'b1;
        cyc();

        // Secret 1-2-3, guess 1-3-2 -> 1A2B.
        pulse_new_game();
        send(12'h321);
        check("secret_state", state, 1);
        check("secret_no_vld", score_vld, 0);
        send(12'h231);
        check("g132_vld", score_vld, 1);
        check("g132_a", score_a, 1);
        check("g132_b", score_b, 2);
        check("g132_tries", tries, 1);
        check("g132_state", state, 1);

        // Illegal inputs: repeated digit, non-BCD digit.
        send(12'h211);
        check("dup_err", err, 1);
        check("dup_tries", tries, 1);
        check("dup_hist", hist_cnt, 1);
        send(12'h3A1);
        check("bcd_err", err, 1);
        check("bcd_vld", score_vld, 0);

        // new_game beats a coincident legal strobe.
        iNum = 12'h231; iNumRdy = 1'b1; new_game = 1'b1;
        cyc();
        iNumRdy = 1'b0; new_game = 1'b0;
        check("ng_state", state, 0);
        check("ng_vld", score_vld, 0);
        check("ng_tries", tries, 0);

        // Win, then further guesses are ignored.
        send(12'h654);
        send(12'h654);
        check("win_a", score_a, 3);
        check("win_b", score_b, 0);
        check("win_state", state, 2);
        send(12'h231);
        check("win_ign_vld", score_vld, 0);
        check("win_ign_err", err, 0);

        // Asynchronous reset mid-game with tries = 4.
        pulse_new_game();
        send(12'h321);
        for (int k = 0; k < 4; k++) send(g_list[k]);
        check("pre_rst_tries", tries, 4);
        reset = 1'b0;
        #1;
        check("arst_state", state, 0);
        check("arst_tries", tries, 0);
        check("arst_hist", hist_cnt, 0);
        check("arst_a", score_a, 0);
        check("arst_guess", hist_rd_guess, 0);
        cyc();
        reset = 1'b1;
        cyc();

        // Ten wrong guesses: LOSE, history wraps.
        send(12'h321);
        for (int k = 0; k < 10; k++) send(g_list[k]);
        check("lose_state", state, 3);
        check("lose_a", score_a, 0);
        check("lose_b", score_b, 0);
        check("lose_tries", tries, 10);
        check("lose_hcnt", hist_cnt, 8);
`ifdef SECRET_REVEAL_EN
        check("lose_secret", secret_out, 12'h321);
`endif
        hist_rd_idx = 3'd0;
        #1;
        check("hist_idx0", hist_rd_guess, 12'h987);
        hist_rd_idx = 3'd7;
        #1;
        check("hist_idx7", hist_rd_guess, 12'h067);
        send(12'h321);
        check("lose_ign_err", err, 0);
        check("lose_ign_vld", score_vld, 0);

        // Randomised play.
        for (int n = 0; n < 4000; n++) begin
            int r;
            new_game = ($urandom_range(0, 99) < ((m_state >= 2) ? 30 : 2));
            iNumRdy = ($urandom_range(0, 99) < 50);
            r = $urandom_range(0, 9);
            if (r == 0) iNum = 12'($urandom);
            else if (r == 1) iNum = m_secret;
            else iNum = rand_legal();
            hist_rd_idx = 3'($urandom_range(0, 7));
            cyc();
        end
        iNumRdy = 1'b0;
        new_game = 1'b0;
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
